// File: rtl/tpu_host_link.sv
`default_nettype none
// ============================================================================
// tpu_host_link -- host-side pin driver for tt_um_tpu: strobed command
// transfers on ui/uio, busy wait, uo readout stream.            rev 1.0
// ============================================================================
module tpu_host_link #(
    parameter int STRB_CYCLES = 2,
    parameter int READ_LAT    = 2,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       timeout_err,
    output logic       idle,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio_out,
    output logic [7:0] pin_uio_oe,
    input  logic [7:0] pin_uo,
    input  logic [7:0] pin_uio_in
);

    localparam logic [2:0] OP_LOAD_A = 3'd1;
    localparam logic [2:0] OP_LOAD_B = 3'd2;
    localparam logic [2:0] OP_START  = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;

    localparam int MAX_A   = (TIMEOUT > READ_LAT) ? TIMEOUT : READ_LAT;
    localparam int MAX_B   = (STRB_CYCLES > SYNC_STAGES) ? STRB_CYCLES : SYNC_STAGES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] STRB_LAST = CNT_W'(STRB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SYNC_MIN  = CNT_W'(SYNC_STAGES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_STROBE    = 3'd2,
        S_GAP       = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_READ_WAIT = 3'd5,
        S_RESP      = 3'd6
    } state_t;

    state_t                 state_q;
    logic [2:0]             op_q;
    logic [7:0]             data_q;
    logic                   strobe_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rsp_valid_q;
    logic [7:0]             rsp_data_q;
    logic                   timeout_q;
    logic                   cmd_ready_q;
    logic                   idle_q;

    logic w_busy_s;
    logic w_real_op;
    logic w_unused_uio;

    assign w_busy_s     = sync_q[SYNC_STAGES-1];
    assign w_real_op    = (cmd_op >= OP_LOAD_A) && (cmd_op <= OP_READ);
    assign w_unused_uio = ^pin_uio_in[6:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_uio_in[7]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            data_q      <= 8'h00;
            strobe_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            timeout_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    idle_q      <= 1'b1;
                    // NOP and reserved opcodes are accepted but leave the pins untouched
                    if (cmd_valid && cmd_ready_q && w_real_op) begin
                        op_q        <= cmd_op;
                        data_q      <= (cmd_op == OP_LOAD_A || cmd_op == OP_LOAD_B) ? cmd_data : 8'h00;
                        cmd_ready_q <= 1'b0;
                        idle_q      <= 1'b0;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    strobe_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= S_STROBE;
                end
                S_STROBE: begin
                    if (cnt_q == STRB_LAST) begin
                        strobe_q <= 1'b0;
                        state_q  <= S_GAP;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                S_GAP: begin
                    cnt_q <= '0;
                    if (op_q == OP_START) begin
                        state_q <= S_WAIT_BUSY;
                    end else if (op_q == OP_READ) begin
                        state_q <= S_READ_WAIT;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        idle_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAIT_BUSY: begin
                    // Minimum dwell lets the synchroniser reflect the chip's busy response
                    if (cnt_q >= SYNC_MIN && !w_busy_s) begin
                        cmd_ready_q <= 1'b1;
                        idle_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_q   <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        idle_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                S_READ_WAIT: begin
                    if (cnt_q == RD_LAST) begin
                        rsp_data_q  <= pin_uo;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        idle_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = timeout_q;
    assign idle        = idle_q;
    assign pin_ui      = data_q;
    assign pin_uio_out = {4'h0, strobe_q, op_q};
    assign pin_uio_oe  = 8'h0F;

endmodule
`default_nettype wire

// File: tb/tb_tpu_host_link.sv
`default_nettype none
// tb_tpu_host_link -- randomized command stream against a transaction-level
// model of the host link, plus a short-timeout instance for the busy watchdog.
module tb_tpu_host_link;

    localparam int STRB     = 2;
    localparam int RLAT     = 2;
    localparam int SYNC     = 2;
    localparam int TO_SHORT = 16;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LA    = 3'd1;
    localparam logic [2:0] OP_LB    = 3'd2;
    localparam logic [2:0] OP_START = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       timeout_err, idle;
    logic [7:0] pin_ui, pin_uio_out, pin_uio_oe, pin_uo, pin_uio_in;
    logic       busy;
    logic [6:0] uio_junk;

    logic       t_cmd_valid, t_cmd_ready;
    logic [2:0] t_cmd_op;
    logic [7:0] t_cmd_data;
    logic       t_rsp_valid;
    logic [7:0] t_rsp_data;
    logic       t_timeout_err, t_idle;
    logic [7:0] t_pin_ui, t_pin_uio_out, t_pin_uio_oe;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q[$];

    assign pin_uio_in = {busy, uio_junk};

    always #5 clk = ~clk;

    tpu_host_link #(
        .STRB_CYCLES(STRB), .READ_LAT(RLAT), .TIMEOUT(1024), .SYNC_STAGES(SYNC)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .timeout_err(timeout_err), .idle(idle),
        .pin_ui(pin_ui), .pin_uio_out(pin_uio_out), .pin_uio_oe(pin_uio_oe),
        .pin_uo(pin_uo), .pin_uio_in(pin_uio_in)
    );

    tpu_host_link #(
        .STRB_CYCLES(STRB), .READ_LAT(RLAT), .TIMEOUT(TO_SHORT), .SYNC_STAGES(SYNC)
    ) u_dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op), .cmd_data(t_cmd_data),
        .rsp_valid(t_rsp_valid), .rsp_ready(1'b0), .rsp_data(t_rsp_data),
        .timeout_err(t_timeout_err), .idle(t_idle),
        .pin_ui(t_pin_ui), .pin_uio_out(t_pin_uio_out), .pin_uio_oe(t_pin_uio_oe),
        .pin_uo(8'h00), .pin_uio_in(8'h80)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pin-level monitor: every strobe pulse must match the next queued transfer
    logic        mon_prev_strb = 1'b0;
    logic [10:0] mon_prev_pins = '0;
    logic [10:0] mon_cur       = '0;
    int          mon_len       = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_prev_strb = 1'b0;
            mon_prev_pins = '0;
            mon_len       = 0;
        end else begin
            check_eq("uio_hi_zero", 32'(pin_uio_out[7:4]), 32'd0);
            check_eq("uio_oe", 32'(pin_uio_oe), 32'h0F);
            if (pin_uio_out[3]) begin
                if (!mon_prev_strb) begin
                    check_eq("setup_cycle", 32'(mon_prev_pins), 32'({pin_uio_out[2:0], pin_ui}));
                    check_eq("xfer_queued", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0)
                        check_eq("xfer_pins", 32'({pin_uio_out[2:0], pin_ui}), 32'(exp_q.pop_front()));
                    mon_cur = {pin_uio_out[2:0], pin_ui};
                    mon_len = 1;
                end else begin
                    mon_len++;
                    check_eq("strobe_hold", 32'({pin_uio_out[2:0], pin_ui}), 32'(mon_cur));
                end
            end else if (mon_prev_strb) begin
                check_eq("strobe_len", mon_len, STRB);
            end
            mon_prev_strb = pin_uio_out[3];
            mon_prev_pins = {pin_uio_out[2:0], pin_ui};
        end
    end

    // Present a command, scribbling the payload until the cycle it is accepted
    task automatic send(input logic [2:0] op, input logic [7:0] data, output int n);
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            cmd_op   = 3'($urandom);
            cmd_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check_eq("accept_timely", 32'(n < 200), 32'd1);
        cmd_op   = op;
        cmd_data = data;
        if (op >= OP_LA && op <= OP_READ)
            exp_q.push_back({op, (op == OP_LA || op == OP_LB) ? data : 8'h00});
        @(posedge clk);
    endtask

    // Count falling edges after the accept until ready (or response), dropping busy on the way
    task automatic wait_for(input bit watch_rsp, input int drop_at, output int j);
        j = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            j++;
            if (j == drop_at) busy = 1'b0;
        end while (!(watch_rsp ? rsp_valid : cmd_ready) && j < 2000);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input int busy_len,
                           input int stall, input logic [7:0] uo_val, output int j);
        int          n;
        int          exp_j;
        logic [10:0] pins_before;
        j           = 0;
        busy        = (op == OP_START) && (busy_len > 0);
        uio_junk    = 7'($urandom);
        pin_uo      = uo_val;
        pins_before = {pin_uio_out[2:0], pin_ui};
        send(op, data, n);
        if (op == OP_LA || op == OP_LB) begin
            wait_for(1'b0, 0, j);
            check_eq("load_turnaround", j, STRB + 3);
        end else if (op == OP_START) begin
            // leave after the minimum dwell and once the busy fall has crossed the synchroniser
            exp_j = STRB + 4 + SYNC;
            if (busy_len > 0 && busy_len + SYNC + 1 > exp_j) exp_j = busy_len + SYNC + 1;
            wait_for(1'b0, busy_len, j);
            check_eq("start_turnaround", j, exp_j);
            check_eq("start_no_timeout", 32'(timeout_err), 32'd0);
        end else if (op == OP_READ) begin
            wait_for(1'b1, 0, j);
            check_eq("read_latency", j, STRB + 3 + RLAT);
            check_eq("read_data", 32'(rsp_data), 32'(uo_val));
            for (int s = 0; s < stall; s++) begin
                pin_uo = 8'($urandom);
                @(negedge clk);
                check_eq("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check_eq("rsp_hold_data", 32'(rsp_data), 32'(uo_val));
                check_eq("rsp_hold_nordy", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check_eq("rsp_done_valid", 32'(rsp_valid), 32'd0);
            check_eq("rsp_done_ready", 32'(cmd_ready), 32'd1);
            check_eq("rsp_done_idle", 32'(idle), 32'd1);
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check_eq("nop_ready", 32'(cmd_ready), 32'd1);
            check_eq("nop_idle", 32'(idle), 32'd1);
            check_eq("nop_pins", 32'({pin_uio_out[2:0], pin_ui}), 32'(pins_before));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int j, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
        rsp_ready = 1'b0; pin_uo = 8'h00; busy = 1'b0; uio_junk = 7'h2A;
        t_cmd_valid = 1'b0; t_cmd_op = 3'd0; t_cmd_data = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd0);
        check_eq("rst_pin_ui", 32'(pin_ui), 32'd0);
        check_eq("rst_uio_out", 32'(pin_uio_out), 32'd0);
        check_eq("rst_uio_oe", 32'(pin_uio_oe), 32'h0F);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_rst_idle", 32'(idle), 32'd1);

        run_cmd(OP_LA, 8'hA5, 0, 0, 8'h00, j);

        send(OP_LA, 8'h11, n);
        check_eq("b2b_first_wait", n, 0);
        send(OP_LB, 8'hC3, n);
        check_eq("accept_interval", n + 1, STRB + 3);
        wait_for(1'b0, 0, j);
        check_eq("b2b_turnaround", j, STRB + 3);

        run_cmd(OP_START, 8'h77, 20, 0, 8'h00, j);
        check_eq("busy_release", j - 20, SYNC + 1);

        // Busy stuck high on the short-timeout instance
        @(negedge clk);
        check_eq("to_ready", 32'(t_cmd_ready), 32'd1);
        t_cmd_valid = 1'b1;
        t_cmd_op    = OP_START;
        @(negedge clk);
        t_cmd_valid = 1'b0;
        check_eq("to_err_early", 32'(t_timeout_err), 32'd0);
        j = 1;
        while (!t_cmd_ready && j < 200) begin
            @(negedge clk);
            j++;
        end
        check_eq("to_cycles", j, STRB + 3 + TO_SHORT);
        check_eq("to_err_set", 32'(t_timeout_err), 32'd1);
        check_eq("to_idle", 32'(t_idle), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("to_err_sticky", 32'(t_timeout_err), 32'd1);

        run_cmd(OP_READ, 8'hFF, 0, 10, 8'h3C, j);

        // Reset in the middle of a LOAD_B strobe
        send(OP_LB, 8'h5A, n);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_strobe_on", 32'(pin_uio_out[3]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_strobe_off", 32'(pin_uio_out), 32'd0);
        check_eq("mid_rst_pin_ui", 32'(pin_ui), 32'd0);
        check_eq("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("after_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("to_err_cleared", 32'(t_timeout_err), 32'd0);
        run_cmd(OP_LA, 8'h96, 0, 0, 8'h00, j);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_cmd(op, 8'($urandom), int'($urandom_range(0, 30)), int'($urandom_range(0, 4)),
                    8'($urandom), j);
        end

        repeat (3) @(negedge clk);
        check_eq("xfer_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
